// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V opcode constants and immediate format codes
package riscv_pkg;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_BAD} fmt_e;
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational opcode classification and immediate extraction
module imm_extract import riscv_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int CSR_ZIMM = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
    fmt_e f;
    logic [6:0] op;
    assign op = instr[6:0];
    // classify by opcode, then select the matching sign-/zero-extended layout
    always_comb begin
        f = (op == OP_IMM || op == LOAD || op == JALR) ? FMT_I :
            (op == STORE)                              ? FMT_S :
            (op == BRANCH)                             ? FMT_B :
            (op == JAL)                                ? FMT_J :
            (op == LUI || op == AUIPC)                 ? FMT_U :
            (op == OP)                                 ? FMT_R :
            (op == SYSTEM)                             ? ((CSR_ZIMM != 0 && instr[14]) ? FMT_Z : FMT_I) :
                                                         FMT_BAD;
        imm = (f == FMT_I) ? XLEN'($signed(instr[31:20])) :
              (f == FMT_S) ? XLEN'($signed({instr[31:25], instr[11:7]})) :
              (f == FMT_B) ? XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})) :
              (f == FMT_J) ? XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})) :
              (f == FMT_U) ? XLEN'($signed({instr[31:12], 12'b0})) :
              (f == FMT_Z) ? XLEN'(instr[19:15]) :
                             '0;
        fmt = f;
        illegal = f == FMT_BAD;
    end
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate-decode stage with a 2-entry skid buffer
module imm_decode_stage import riscv_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int CSR_ZIMM = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } slot_t;
    state_e state, state_nx;
    slot_t main_q, skid_q, dec;
    logic [XLEN-1:0] dec_imm;
    logic [2:0] dec_fmt;
    logic dec_ill, accept, drain;
    imm_extract #(.XLEN(XLEN), .CSR_ZIMM(CSR_ZIMM)) u_ext (
        .instr(in_instr), .imm(dec_imm), .fmt(dec_fmt), .illegal(dec_ill)
    );
    assign dec = '{instr: in_instr, pc: in_pc, imm: dec_imm, fmt: dec_fmt, illegal: dec_ill};
    assign accept = in_valid && in_ready && !flush;
    assign drain = out_valid && out_ready;
    // state register; in_ready is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state <= state_nx;
            in_ready <= state_nx != FULL;
        end
    end
    // next state: flush empties the buffer and wins over any transfer
    always_comb begin
        state_nx = flush            ? EMPTY :
                   (state == EMPTY) ? (accept ? ONE : EMPTY) :
                   (state == ONE)   ? ((accept && !drain) ? FULL : (drain && !accept) ? EMPTY : ONE) :
                                      (drain ? ONE : FULL);
    end
    // outputs come straight from the main slot
    always_comb begin
        out_valid = state != EMPTY;
        out_instr = main_q.instr;
        out_pc = main_q.pc;
        out_imm = main_q.imm;
        out_fmt = main_q.fmt;
        out_illegal = main_q.illegal;
    end
    // slot loads: main takes new input or the skid entry; skid only fills from ONE without drain
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (accept && (state == EMPTY || (state == ONE && drain)))
                main_q <= dec;
            else if (state == FULL && drain)
                main_q <= skid_q;
            if (accept && state == ONE && !drain)
                skid_q <= dec;
        end
    end
endmodule
